l1d_rd_bank_arb: RTL and testbench
==================================

Name: l1d_rd_bank_arb

Overview:
Multi-port, multi-bank arbiter between N load-pipeline read requesters (s0/s1 read protocol) and a banked L1D data array. Each cycle, in s0, it steers every read request to the bank selected by its paddr. A rotating-priority arbiter per bank grants one cache line. Losers get s1_conflict one cycle later. Sits between the LSU pipes and the L1D banks; it replaces the single-port point-to-point read connection.

Parameters:
N_PORTS, 2, number of read requesters (1..4)
N_BANKS, 4, number of data banks (power of two, >=2)
PADDR_W, riscv_pkg::PADDR_W, physical address width
DATA_W, msrh_conf_pkg::DCACHE_DATA_W, line data width
BANK_LSB, 6, lowest paddr bit of the bank index; the bank index is paddr[BANK_LSB +: log2(N_BANKS)]
LINE_LSB, 6, lowest paddr bit of the line address; the line address is paddr[PADDR_W-1:LINE_LSB]

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_rd_s0_valid  in  N_PORTS  per-port read request
i_rd_s0_paddr  in  N_PORTS x PADDR_W  per-port request address
o_rd_s1_hit  out  N_PORTS  granted and bank hit
o_rd_s1_miss  out  N_PORTS  granted and bank miss
o_rd_s1_conflict  out  N_PORTS  not granted; requester must replay
o_rd_s1_data  out  N_PORTS x DATA_W  line data from the granted bank
i_wr_valid  in  1  L1D write/refill owns a bank this cycle
i_wr_paddr  in  PADDR_W  write address; its bank is blocked for reads
o_bank_s0_valid  out  N_BANKS  per-bank read request (combinational)
o_bank_s0_paddr  out  N_BANKS x PADDR_W  per-bank granted address
i_bank_s1_hit  in  N_BANKS  bank tag hit, one cycle after o_bank_s0_valid
i_bank_s1_miss  in  N_BANKS  bank tag miss
i_bank_s1_data  in  N_BANKS x DATA_W  bank read data

Behaviour:
- Clocking: single clock i_clk. Reset i_reset_n is asynchronous and active-low.
- On reset:
  - all s1 pipeline registers clear (s1 valid, s1 granted, s1 bank index);
  - all per-bank priority pointers clear to 0;
  - o_rd_s1_* = 0.
- o_bank_s0_* is combinational from s0 inputs. It is 0 while in reset because the inputs are gated by i_reset_n internally.
- s0 arbitration, per bank b:
  - candidates = ports with valid & bank(paddr)==b;
  - if i_wr_valid and bank(i_wr_paddr)==b: no read grant, and every candidate loses;
  - otherwise the winner is the first candidate at or after ptr[b], scanning upward modulo N_PORTS;
  - o_bank_s0_valid[b] = 1 when there is a winner, and o_bank_s0_paddr[b] = the winner's paddr;
  - same-line merge: any other candidate whose line address equals the winner's line address is also granted and shares the winner's s1 result.
- Pointer update: ptr[b] <= winner+1 (mod N_PORTS) only when bank b granted and at least one candidate of b was not granted. Otherwise ptr[b] holds.
- s1 (registered, latency 1):
  - o_rd_s1_hit[p] = s1_granted[p] & i_bank_s1_hit[s1_bank[p]];
  - o_rd_s1_miss[p] = s1_granted[p] & i_bank_s1_miss[s1_bank[p]];
  - o_rd_s1_conflict[p] = s1_valid[p] & ~s1_granted[p];
  - o_rd_s1_data[p] = i_bank_s1_data[s1_bank[p]] when granted, else 0.
- Invariants:
  - per port, hit, miss and conflict are mutually exclusive, and at most one is 1;
  - exactly one of them is 1 whenever s1_valid[p], given that the bank asserts hit xor miss.
- Boundaries:
  - no requests: all bank valids 0 and pointers unchanged;
  - N_PORTS=1: the pointer is constant 0;
  - all ports hitting the same bank with distinct lines: one grant per cycle, and the pointer guarantees each port is granted within N_PORTS retries;
  - write blocks the bank: losers replay and the pointer is unchanged;
  - reset asserted mid-request: in-flight s1 results are dropped with no conflict reported.
- Bank data/hit inputs are sampled only through the s1 mux. The block does not buffer bank outputs.

Decomposition:
- msrh_lsu_pkg gains:
  - the localparam DCACHE_BANK_W = log2(N_BANKS);
  - a bank-index extraction function;
  - a line-address compare function.
- One natural sub-module: l1d_rr_pick (N-input rotating-priority picker: request vector + pointer -> one-hot grant plus index), instantiated N_BANKS times.

Test Plan:
1. Port0 reads 0x1000 (bank0), port1 reads 0x1040 (bank1), bank hits -> next cycle both o_rd_s1_hit=1, each with its own bank's data, no conflict.
2. Port0 0x1000 and port1 0x1100 (both bank0, different lines), ptr=0, repeated for 3 cycles -> grants go p0, p1, p0; the loser sees o_rd_s1_conflict=1 each cycle; ptr alternates 1, 0, 1.
3. Port0 0x1008 and port1 0x1010 (same line, bank0) -> single o_bank_s0_valid[0]; both ports get hit=1 with identical data; ptr unchanged.
4. i_wr_valid with wr_paddr 0x2040 (bank1) while port0 reads 0x3040 -> o_bank_s0_valid[1]=0; port0 gets conflict=1; ptr[1] unchanged.
5. Granted read whose bank returns i_bank_s1_miss=1 -> o_rd_s1_miss=1, hit=0, conflict=0.
6. Assert i_reset_n=0 mid-cycle with an s1 result pending -> all o_rd_s1_* drop to 0 immediately; after release the pointers are 0 and the first contention grants port0.

Source files
------------

// File: rtl/l1d_rd_bank_arb_pkg.sv
// l1d_rd_bank_arb_pkg: shared widths and address helpers for the L1D read bank arbiter.
package l1d_rd_bank_arb_pkg;
    localparam int PADDR_W = 40;
    localparam int DCACHE_DATA_W = 64;
    localparam int DCACHE_BANKS = 4;
    localparam int DCACHE_BANK_W = $clog2(DCACHE_BANKS);

    function automatic int bank_of(input logic [PADDR_W-1:0] pa, input int lsb, input int n_banks);
        logic [PADDR_W-1:0] s;
        s = pa >> lsb;
        return int'(s[15:0]) & (n_banks - 1);
    endfunction

    function automatic logic same_line(input logic [PADDR_W-1:0] a, input logic [PADDR_W-1:0] b, input int lsb);
        return (a >> lsb) == (b >> lsb);
    endfunction
endpackage

// File: rtl/l1d_rd_bank_arb_rr_pick.sv
// l1d_rr_pick: rotating-priority picker, first request at or after ptr wins.
module l1d_rr_pick #(
    parameter int N = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    // Scan from the farthest offset down so the closest-to-ptr request overwrites last.
    always_comb begin
        grant = '0;
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                grant = '0;
                grant[(int'(ptr) + i) % N] = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
            end
        end
    end
endmodule

// File: rtl/l1d_rd_bank_arb.sv
// l1d_rd_bank_arb: steers N load-pipe s0 reads onto banked L1D with per-bank
// rotating priority, same-line merging, write blocking and s1 result muxing.
module l1d_rd_bank_arb #(
    parameter int N_PORTS = 2,
    parameter int N_BANKS = 4,
    parameter int PADDR_W = l1d_rd_bank_arb_pkg::PADDR_W,
    parameter int DATA_W = l1d_rd_bank_arb_pkg::DCACHE_DATA_W,
    parameter int BANK_LSB = 6,
    parameter int LINE_LSB = 6
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic [N_PORTS-1:0]                i_rd_s0_valid,
    input  logic [N_PORTS-1:0][PADDR_W-1:0]   i_rd_s0_paddr,
    output logic [N_PORTS-1:0]                o_rd_s1_hit,
    output logic [N_PORTS-1:0]                o_rd_s1_miss,
    output logic [N_PORTS-1:0]                o_rd_s1_conflict,
    output logic [N_PORTS-1:0][DATA_W-1:0]    o_rd_s1_data,
    input  logic                              i_wr_valid,
    input  logic [PADDR_W-1:0]                i_wr_paddr,
    output logic [N_BANKS-1:0]                o_bank_s0_valid,
    output logic [N_BANKS-1:0][PADDR_W-1:0]   o_bank_s0_paddr,
    input  logic [N_BANKS-1:0]                i_bank_s1_hit,
    input  logic [N_BANKS-1:0]                i_bank_s1_miss,
    input  logic [N_BANKS-1:0][DATA_W-1:0]    i_bank_s1_data
);
    import l1d_rd_bank_arb_pkg::*;

    localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
    localparam int BW = $clog2(N_BANKS);

    logic [N_PORTS-1:0] vld;
    logic               wr;
    logic [N_PORTS-1:0] bank_grant [N_BANKS];
    logic [PW-1:0]      ptr [N_BANKS];
    logic [PW-1:0]      ptr_nxt [N_BANKS];
    logic [N_PORTS-1:0] granted;
    logic [N_PORTS-1:0] s1_valid;
    logic [N_PORTS-1:0] s1_granted;
    logic [BW-1:0]      s1_bank [N_PORTS];

    // Gating by reset keeps the bank request lines quiet while reset is held.
    assign vld = i_rd_s0_valid & {N_PORTS{i_reset_n}};
    assign wr = i_wr_valid & i_reset_n;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [N_PORTS-1:0] cand;
        logic [N_PORTS-1:0] req;
        logic [N_PORTS-1:0] pick;
        logic [N_PORTS-1:0] grant;
        logic [PW-1:0]      idx;
        logic               any;
        logic               blocked;
        always_comb begin
            cand = '0;
            for (int p = 0; p < N_PORTS; p++)
                cand[p] = vld[p] && bank_of(i_rd_s0_paddr[p], BANK_LSB, N_BANKS) == b;
        end
        assign blocked = wr && bank_of(i_wr_paddr, BANK_LSB, N_BANKS) == b;
        assign req = blocked ? '0 : cand;
        l1d_rr_pick #(.N(N_PORTS), .IW(PW)) u_pick (
            .req(req), .ptr(ptr[b]), .grant(pick), .idx(idx), .any(any)
        );
        // Same-line candidates ride along with the winner's lookup.
        always_comb begin
            grant = '0;
            for (int p = 0; p < N_PORTS; p++)
                grant[p] = any && cand[p] && same_line(i_rd_s0_paddr[p], i_rd_s0_paddr[idx], LINE_LSB);
        end
        assign bank_grant[b] = grant | pick;
        assign o_bank_s0_valid[b] = any;
        assign o_bank_s0_paddr[b] = any ? i_rd_s0_paddr[idx] : '0;
        assign ptr_nxt[b] = (any && |(cand & ~bank_grant[b])) ? (idx == PW'(N_PORTS - 1) ? '0 : idx + 1'b1) : ptr[b];
    end

    always_comb begin
        granted = '0;
        for (int p = 0; p < N_PORTS; p++)
            for (int b = 0; b < N_BANKS; b++)
                granted[p] = granted[p] | bank_grant[b][p];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid <= '0;
            s1_granted <= '0;
            for (int p = 0; p < N_PORTS; p++) s1_bank[p] <= '0;
            for (int b = 0; b < N_BANKS; b++) ptr[b] <= '0;
        end else begin
            s1_valid <= vld;
            s1_granted <= granted;
            for (int p = 0; p < N_PORTS; p++) s1_bank[p] <= BW'(bank_of(i_rd_s0_paddr[p], BANK_LSB, N_BANKS));
            for (int b = 0; b < N_BANKS; b++) ptr[b] <= ptr_nxt[b];
        end
    end

    always_comb begin
        o_rd_s1_hit = '0;
        o_rd_s1_miss = '0;
        o_rd_s1_conflict = '0;
        o_rd_s1_data = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            o_rd_s1_hit[p] = s1_granted[p] & i_bank_s1_hit[s1_bank[p]];
            o_rd_s1_miss[p] = s1_granted[p] & i_bank_s1_miss[s1_bank[p]];
            o_rd_s1_conflict[p] = s1_valid[p] & ~s1_granted[p];
            o_rd_s1_data[p] = s1_granted[p] ? i_bank_s1_data[s1_bank[p]] : '0;
        end
    end
endmodule

// File: tb/tb_l1d_rd_bank_arb.sv
// tb_l1d_rd_bank_arb: directed scenarios for the L1D read bank arbiter
// (2 ports, 4 banks, 40-bit paddr, 64-bit data).
module tb_l1d_rd_bank_arb;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        rd_valid = '0;
    logic [1:0][39:0]  rd_paddr = '0;
    logic [1:0]        s1_hit;
    logic [1:0]        s1_miss;
    logic [1:0]        s1_conflict;
    logic [1:0][63:0]  s1_data;
    logic              wr_valid = 1'b0;
    logic [39:0]       wr_paddr = '0;
    logic [3:0]        bank_valid;
    logic [3:0][39:0]  bank_paddr;
    logic [3:0]        bank_hit = 4'hF;
    logic [3:0]        bank_miss = 4'h0;
    logic [3:0][63:0]  bank_data;
    int nvec = 0;
    int nerr = 0;

    l1d_rd_bank_arb dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rd_s0_valid(rd_valid), .i_rd_s0_paddr(rd_paddr),
        .o_rd_s1_hit(s1_hit), .o_rd_s1_miss(s1_miss),
        .o_rd_s1_conflict(s1_conflict), .o_rd_s1_data(s1_data),
        .i_wr_valid(wr_valid), .i_wr_paddr(wr_paddr),
        .o_bank_s0_valid(bank_valid), .o_bank_s0_paddr(bank_paddr),
        .i_bank_s1_hit(bank_hit), .i_bank_s1_miss(bank_miss), .i_bank_s1_data(bank_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] bdata(input int b);
        return {8{8'(8'hA0 + b)}};
    endfunction

    task automatic drive(input logic [1:0] v, input logic [39:0] a0, input logic [39:0] a1);
        rd_valid = v;
        rd_paddr[0] = a0;
        rd_paddr[1] = a1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rd_valid = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(2'b11, 40'h1000, 40'h1040);
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (bank_valid !== 4'b0000) begin nerr++; $display("FAIL reset_bank_valid got=%b exp=0000", bank_valid); end
        nvec++;
        if ({s1_hit, s1_miss, s1_conflict} !== 6'b0) begin nerr++; $display("FAIL reset_s1 got=%b exp=000000", {s1_hit, s1_miss, s1_conflict}); end
        nvec++;
        if (s1_data !== '0) begin nerr++; $display("FAIL reset_data got=%h exp=0", s1_data); end
        rd_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_two_banks();
        drive(2'b11, 40'h1000, 40'h1040);
        nvec++;
        if (bank_valid !== 4'b0011) begin nerr++; $display("FAIL two_banks_valid got=%b exp=0011", bank_valid); end
        nvec++;
        if (bank_paddr[0] !== 40'h1000 || bank_paddr[1] !== 40'h1040) begin nerr++; $display("FAIL two_banks_paddr got=%h/%h exp=1000/1040", bank_paddr[0], bank_paddr[1]); end
        tick();
        nvec++;
        if (s1_hit !== 2'b11 || s1_conflict !== 2'b00) begin nerr++; $display("FAIL two_banks_s1 hit=%b conf=%b exp=11/00", s1_hit, s1_conflict); end
        nvec++;
        if (s1_data[0] !== bdata(0) || s1_data[1] !== bdata(1)) begin nerr++; $display("FAIL two_banks_data got=%h/%h exp=%h/%h", s1_data[0], s1_data[1], bdata(0), bdata(1)); end
    endtask

    task automatic test_contention();
        for (int k = 0; k < 3; k++) begin
            logic [1:0] w;
            w = (k % 2 == 0) ? 2'b01 : 2'b10;
            drive(2'b11, 40'h1000, 40'h1100);
            nvec++;
            if (bank_valid !== 4'b0001 || bank_paddr[0] !== (w[0] ? 40'h1000 : 40'h1100)) begin
                nerr++; $display("FAIL contention_s0[%0d] valid=%b paddr=%h exp winner=%b", k, bank_valid, bank_paddr[0], w);
            end
            tick();
            nvec++;
            if (s1_hit !== w || s1_conflict !== ~w) begin nerr++; $display("FAIL contention_s1[%0d] hit=%b conf=%b exp=%b/%b", k, s1_hit, s1_conflict, w, ~w); end
        end
    endtask

    task automatic test_same_line();
        drive(2'b11, 40'h1008, 40'h1010);
        nvec++;
        if (bank_valid !== 4'b0001 || bank_paddr[0] !== 40'h1010) begin nerr++; $display("FAIL same_line_s0 valid=%b paddr=%h exp=0001/1010", bank_valid, bank_paddr[0]); end
        tick();
        nvec++;
        if (s1_hit !== 2'b11 || s1_conflict !== 2'b00) begin nerr++; $display("FAIL same_line_s1 hit=%b conf=%b exp=11/00", s1_hit, s1_conflict); end
        nvec++;
        if (s1_data[0] !== bdata(0) || s1_data[1] !== bdata(0)) begin nerr++; $display("FAIL same_line_data got=%h/%h exp=%h", s1_data[0], s1_data[1], bdata(0)); end
        drive(2'b11, 40'h1000, 40'h1100);
        nvec++;
        if (bank_paddr[0] !== 40'h1100) begin nerr++; $display("FAIL same_line_ptr_hold paddr=%h exp=1100", bank_paddr[0]); end
        tick();
        nvec++;
        if (s1_conflict !== 2'b01) begin nerr++; $display("FAIL same_line_ptr_conf got=%b exp=01", s1_conflict); end
    endtask

    task automatic test_wr_block();
        wr_valid = 1'b1;
        wr_paddr = 40'h2040;
        drive(2'b01, 40'h3040, 40'h0);
        nvec++;
        if (bank_valid !== 4'b0000) begin nerr++; $display("FAIL wr_block_valid got=%b exp=0000", bank_valid); end
        tick();
        wr_valid = 1'b0;
        nvec++;
        if (s1_conflict !== 2'b01 || s1_hit !== 2'b00) begin nerr++; $display("FAIL wr_block_s1 conf=%b hit=%b exp=01/00", s1_conflict, s1_hit); end
        drive(2'b11, 40'h1040, 40'h1140);
        nvec++;
        if (bank_valid !== 4'b0010 || bank_paddr[1] !== 40'h1040) begin nerr++; $display("FAIL wr_block_ptr valid=%b paddr=%h exp=0010/1040", bank_valid, bank_paddr[1]); end
        tick();
        nvec++;
        if (s1_hit !== 2'b01 || s1_conflict !== 2'b10) begin nerr++; $display("FAIL wr_block_after hit=%b conf=%b exp=01/10", s1_hit, s1_conflict); end
    endtask

    task automatic test_miss();
        bank_hit = 4'h0;
        bank_miss = 4'b0100;
        drive(2'b01, 40'h1080, 40'h0);
        nvec++;
        if (bank_valid !== 4'b0100) begin nerr++; $display("FAIL miss_valid got=%b exp=0100", bank_valid); end
        tick();
        nvec++;
        if (s1_miss !== 2'b01 || s1_hit !== 2'b00 || s1_conflict !== 2'b00) begin nerr++; $display("FAIL miss_s1 miss=%b hit=%b conf=%b exp=01/00/00", s1_miss, s1_hit, s1_conflict); end
        nvec++;
        if (s1_data[0] !== bdata(2)) begin nerr++; $display("FAIL miss_data got=%h exp=%h", s1_data[0], bdata(2)); end
        bank_hit = 4'hF;
        bank_miss = 4'h0;
    endtask

    task automatic test_idle();
        drive(2'b00, 40'h1000, 40'h1100);
        nvec++;
        if (bank_valid !== 4'b0000) begin nerr++; $display("FAIL idle_valid got=%b exp=0000", bank_valid); end
        tick();
        nvec++;
        if ({s1_hit, s1_miss, s1_conflict} !== 6'b0) begin nerr++; $display("FAIL idle_s1 got=%b exp=000000", {s1_hit, s1_miss, s1_conflict}); end
    endtask

    task automatic test_reset_mid();
        drive(2'b11, 40'h1000, 40'h1100);
        tick();
        nvec++;
        if (s1_hit !== 2'b01 || s1_conflict !== 2'b10) begin nerr++; $display("FAIL reset_mid_pending hit=%b conf=%b exp=01/10", s1_hit, s1_conflict); end
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({s1_hit, s1_miss, s1_conflict} !== 6'b0 || s1_data !== '0) begin nerr++; $display("FAIL reset_mid_drop s1=%b data=%h exp=0", {s1_hit, s1_miss, s1_conflict}, s1_data); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 40'h1000, 40'h1100);
        nvec++;
        if (bank_paddr[0] !== 40'h1000) begin nerr++; $display("FAIL reset_mid_ptr paddr=%h exp=1000", bank_paddr[0]); end
        tick();
        nvec++;
        if (s1_hit !== 2'b01 || s1_conflict !== 2'b10) begin nerr++; $display("FAIL reset_mid_after hit=%b conf=%b exp=01/10", s1_hit, s1_conflict); end
    endtask

    initial begin
        for (int b = 0; b < 4; b++) bank_data[b] = bdata(b);
        test_reset();
        test_two_banks();
        test_contention();
        test_same_line();
        test_wr_block();
        test_miss();
        test_idle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
